// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory.
// Ports: req_* (request channel), rsp_* (response channel); master/slave modports.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: 2^ADDR_W x 64-bit array with WAIT wait states per access.
// Ports: clk, rst (async, active-high), bus (slave modport), busy (state != IDLE).
// Macro DMEM_ERR_CHECK_EN enables misalignment / out-of-range fault reporting.
module data_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    data_mem_responder_if.slave       bus,
    output logic                      busy
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    logic                r_write;
    logic [63:0]         r_addr;
    logic [1:0]          r_size;
    logic [63:0]         r_wdata;
    logic [63:0]         r_rdata;
    logic                r_err;

    logic [63:0]         r_mem [2**ADDR_W];

    logic                w_accept;
    logic                w_err;
    logic                w_commit;
    logic [63:0]         w_size_mask;
    logic [63:0]         w_addr;
    logic [2:0]          w_off;
    logic [ADDR_W-1:0]   w_idx;
    logic [7:0]          w_be;
    logic [63:0]         w_wdata_sh;
    logic                w_unused_addr;

    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
    assign w_size_mask = (64'd1 << r_size) - 64'd1;

`ifdef DMEM_ERR_CHECK_EN
    assign w_addr = r_addr;
    assign w_err  = ((r_addr & w_size_mask) != 64'd0)
                 || ((r_addr >> (ADDR_W + 3)) != 64'd0);
`else
    // Align down and drop upper bits: accesses wrap modulo the depth.
    assign w_addr = r_addr & ~w_size_mask;
    assign w_err  = 1'b0;
`endif

    assign w_unused_addr = ^{w_addr[63:ADDR_W+3]};
    assign w_off         = w_addr[2:0];
    assign w_idx         = w_addr[ADDR_W+2:3];
    assign w_wdata_sh    = r_wdata << {w_off, 3'b000};
    assign w_commit      = (r_state == ST_ACCESS) && r_write && !w_err;

    always_comb begin
        w_be = 8'h00;
        unique case (r_size)
            2'd0: w_be = 8'h01 << w_off;
            2'd1: w_be = 8'h03 << w_off;
            2'd2: w_be = 8'h0F << w_off;
            2'd3: w_be = 8'hFF;
            default: w_be = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT == 0) begin
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WAIT_CNT;
                    end
                end
            end
            ST_WAIT: begin
                // Last wait cycle when the counter reaches one.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 64'd0;
            r_size  <= 2'd0;
            r_wdata <= 64'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_size  <= bus.req_size;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= (r_write || w_err) ? 64'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end
        end
    end

    // Array is never reset; reset forces IDLE so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (WAIT=2 and WAIT=0 instances).
// Expectations follow the DMEM_ERR_CHECK_EN build setting.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_a;
    logic busy_b;

    int n_tot = 0;
    int n_bad = 0;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    data_mem_responder #(.ADDR_W(8), .WAIT(2)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifa),
        .busy (busy_a)
    );

    data_mem_responder #(.ADDR_W(8), .WAIT(0)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifb),
        .busy (busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_tot++;
        n_bad++;
        $display("FAIL %s timeout", tag);
    endtask

    task automatic xfer(input logic wr, input logic [63:0] ad,
                        input logic [1:0] sz, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er,
                        output int lat);
        int k;
        @(negedge clk);
        ifa.req_valid = 1'b1;
        ifa.req_write = wr;
        ifa.req_addr  = ad;
        ifa.req_size  = sz;
        ifa.req_wdata = wd;
        k = 0;
        while (!ifa.req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) timeout("accept");
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
        ifa.req_addr  = '1;
        ifa.req_wdata = '1;
        ifa.req_size  = 2'd0;
        lat = 0;
        while (!ifa.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) timeout("rsp");
        rd = ifa.rsp_rdata;
        er = ifa.rsp_err;
        @(posedge clk);
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    logic [63:0] exp10;
    int          seen[$];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.req_valid = 1'b0;
        ifa.req_write = 1'b0;
        ifa.req_addr  = 64'd0;
        ifa.req_size  = 2'd0;
        ifa.req_wdata = 64'd0;
        ifa.rsp_ready = 1'b1;
        ifb.req_valid = 1'b0;
        ifb.req_write = 1'b0;
        ifb.req_addr  = 64'd0;
        ifb.req_size  = 2'd3;
        ifb.req_wdata = 64'd0;
        ifb.rsp_ready = 1'b1;

        #12;
        check("rst_rvalid", ifa.rsp_valid, 0);
        check("rst_rdy", ifa.req_ready, 1);
        check("rst_busy", busy_a, 0);
        check("rst_rdata", ifa.rsp_rdata, 0);
        check("rst_err", ifa.rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;

        xfer(1, 64'h20, 2'd3, 64'hCAFEF00D12345678, rd, er, lat);

        xfer(1, 64'h10, 2'd3, 64'h1122334455667788, rd, er, lat);
        check("st_lat", lat, 3);
        check("st_err", er, 0);
        check("st_rdata", rd, 0);
        xfer(0, 64'h10, 2'd3, 64'h0, rd, er, lat);
        check("ld_lat", lat, 3);
        check("ld_data", rd, 64'h1122334455667788);
        check("ld_err", er, 0);

        xfer(1, 64'h13, 2'd0, 64'hAB, rd, er, lat);
        check("sb_err", er, 0);
        xfer(0, 64'h10, 2'd3, 64'h0, rd, er, lat);
        check("sb_merge", rd, 64'h11223344AB667788);

        // Response stall with a second request pending.
        @(negedge clk);
        ifa.rsp_ready = 1'b0;
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b0;
        ifa.req_addr  = 64'h20;
        ifa.req_size  = 2'd3;
        @(posedge clk);
        #1;
        ifa.req_addr = 64'h10;
        lat = 0;
        while (!ifa.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) timeout("stall_rsp");
        check("stall_lat", lat, 3);
        repeat (5) begin
            check("stall_valid", ifa.rsp_valid, 1);
            check("stall_rdata", ifa.rsp_rdata, 64'hCAFEF00D12345678);
            check("stall_rdy", ifa.req_ready, 0);
            @(posedge clk);
            #1;
        end
        ifa.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_busy", busy_a, 0);
        check("hs_rdy", ifa.req_ready, 1);
        @(posedge clk);
        #1;
        check("acc2_busy", busy_a, 1);
        ifa.req_valid = 1'b0;
        lat = 0;
        while (!ifa.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) timeout("acc2_rsp");
        check("acc2_data", ifa.rsp_rdata, 64'h11223344AB667788);
        @(posedge clk);

        // Misaligned half store and out-of-range load.
        xfer(1, 64'h11, 2'd1, 64'hBEEF, rd, er, lat);
        check("mis_lat", lat, 3);
`ifdef DMEM_ERR_CHECK_EN
        check("mis_err", er, 1);
        check("mis_rdata", rd, 0);
        exp10 = 64'h11223344AB667788;
`else
        check("mis_err", er, 0);
        exp10 = 64'h11223344AB66BEEF;
`endif
        xfer(0, 64'h10, 2'd3, 64'h0, rd, er, lat);
        check("mis_entry", rd, exp10);
        xfer(0, 64'h1_0000_0010, 2'd3, 64'h0, rd, er, lat);
        check("oor_lat", lat, 3);
`ifdef DMEM_ERR_CHECK_EN
        check("oor_err", er, 1);
        check("oor_rdata", rd, 0);
`else
        check("oor_err", er, 0);
        check("oor_rdata", rd, exp10);
`endif

        // Reset during wait states aborts the store.
        @(negedge clk);
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b1;
        ifa.req_addr  = 64'h20;
        ifa.req_size  = 2'd3;
        ifa.req_wdata = 64'hDEADBEEF00000000;
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy_a, 1);
        rst = 1'b1;
        #1;
        check("abort_rvalid", ifa.rsp_valid, 0);
        check("abort_idle", busy_a, 0);
        check("abort_rdy", ifa.req_ready, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 64'h20, 2'd3, 64'h0, rd, er, lat);
        check("abort_keep", rd, 64'hCAFEF00D12345678);

        // WAIT=0 back-to-back loads.
        @(negedge clk);
        ifb.req_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (ifb.rsp_valid) begin
                seen.push_back(c);
                check("b2b_rdy", ifb.req_ready, 0);
            end
        end
        ifb.req_valid = 1'b0;
        check("b2b_cnt", 64'(seen.size()), 4);
        foreach (seen[i]) check("b2b_edge", 64'(seen[i]), 64'(2 + 3 * i));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
